alu_arbiter: RTL and testbench

Shares the single combinational `alu` between two requesters of the RV32E core: requester 0 is the execute stage, requester 1 is address/PC generation. The block arbitrates round-robin with a valid/ready handshake and registers the selected operands in front of the ALU. It captures the ALU result into a registered response tagged with the requester ID. One operation completes every two cycles at most.

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered in front of the ALU; the result returns as a one-cycle tagged strobe.
module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_func,
  input  logic        req0_f7,
  output logic        req0_ready,

  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_func,
  input  logic        req1_f7,
  output logic        req1_ready,

  output logic [31:0] alu_value1,
  output logic [31:0] alu_value2,
  output logic [2:0]  alu_func_type,
  output logic        alu_f7_bit,
  input  logic [31:0] alu_result,

  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        id_q;
  logic        gnt0, gnt1;
  logic        accept0, accept1;

  // On a tie, the requester not granted last time wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept0    = req0_valid & gnt0;
  assign accept1    = req1_valid & gnt1;
  assign busy       = (state_q == StExec);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept0 || accept1) state_d = StExec;
      StExec: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers keep the last operation between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_value1    <= '0;
      alu_value2    <= '0;
      alu_func_type <= '0;
      alu_f7_bit    <= 1'b0;
      id_q          <= 1'b0;
      last_grant_q  <= ~PRIO_INIT;
    end else if (accept0) begin
      alu_value1    <= req0_a;
      alu_value2    <= req0_b;
      alu_func_type <= req0_func;
      alu_f7_bit    <= req0_f7;
      id_q          <= 1'b0;
      last_grant_q  <= 1'b0;
    end else if (accept1) begin
      alu_value1    <= req1_a;
      alu_value2    <= req1_b;
      alu_func_type <= req1_func;
      alu_f7_bit    <= req1_f7;
      id_q          <= 1'b1;
      last_grant_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else if (state_q == StExec) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_q;
      rsp_data  <= alu_result;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (PRIO_INIT 0 and 1) share stimulus,
// each fed by its own behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_func = '0, req1_func = '0;
  logic        req0_f7 = 1'b0, req1_f7 = 1'b0;

  logic        d0_r0, d0_r1, d0_f7, d0_rv, d0_id, d0_busy;
  logic [31:0] d0_v1, d0_v2, d0_res, d0_rd;
  logic [2:0]  d0_func;
  logic        d1_r0, d1_r1, d1_f7, d1_rv, d1_id, d1_busy;
  logic [31:0] d1_v1, d1_v2, d1_res, d1_rd;
  logic [2:0]  d1_func;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ALU returns 0 for SLT, SLTU and the SRA encoding.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic f7);
    case (f)
      3'b000:  alu_f = f7 ? a - b : a + b;
      3'b001:  alu_f = a << b[4:0];
      3'b100:  alu_f = a ^ b;
      3'b101:  alu_f = f7 ? 32'h0 : a >> b[4:0];
      3'b110:  alu_f = a | b;
      3'b111:  alu_f = a & b;
      default: alu_f = 32'h0;
    endcase
  endfunction

  always_comb d0_res = alu_f(d0_v1, d0_v2, d0_func, d0_f7);
  always_comb d1_res = alu_f(d1_v1, d1_v2, d1_func, d1_f7);

  alu_arbiter #(.PRIO_INIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req0_f7(req0_f7), .req0_ready(d0_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .req1_f7(req1_f7), .req1_ready(d0_r1),
    .alu_value1(d0_v1), .alu_value2(d0_v2), .alu_func_type(d0_func), .alu_f7_bit(d0_f7),
    .alu_result(d0_res), .rsp_valid(d0_rv), .rsp_id(d0_id), .rsp_data(d0_rd), .busy(d0_busy)
  );

  alu_arbiter #(.PRIO_INIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req0_f7(req0_f7), .req0_ready(d1_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .req1_f7(req1_f7), .req1_ready(d1_r1),
    .alu_value1(d1_v1), .alu_value2(d1_v2), .alu_func_type(d1_func), .alu_f7_bit(d1_f7),
    .alu_result(d1_res), .rsp_valid(d1_rv), .rsp_id(d1_id), .rsp_data(d1_rd), .busy(d1_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2;
    n_vec++;
    if ({d0_v1, d0_v2, d0_func, d0_f7, d0_rv, d0_id, d0_rd, d0_busy, d0_r0, d0_r1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v1=%h v2=%h func=%b f7=%b rv=%b id=%b rd=%h busy=%b, want all 0",
               d0_v1, d0_v2, d0_func, d0_f7, d0_rv, d0_id, d0_rd, d0_busy);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    do_reset();
    req0_a = 32'd5; req0_b = 32'd3; req0_func = 3'b000; req0_f7 = 1'b0;
    // Valid pulsed and dropped before the edge must not be latched.
    req0_valid = 1'b1;
    #1 req0_valid = 1'b0;
    step();
    n_vec++;
    if (d0_busy !== 1'b0) begin
      n_err++; $display("FAIL dropped_valid_busy: got %b want 0", d0_busy);
    end
    req0_valid = 1'b1;
    #1;
    n_vec++;
    if (d0_r0 !== 1'b1 || d0_r1 !== 1'b0) begin
      n_err++; $display("FAIL single_ready: got r0=%b r1=%b want 1 0", d0_r0, d0_r1);
    end
    step();
    req0_valid = 1'b0;
    n_vec++;
    if (d0_busy !== 1'b1 || d0_rv !== 1'b0 || d0_v1 !== 32'd5 || d0_v2 !== 32'd3) begin
      n_err++;
      $display("FAIL single_exec: got busy=%b rv=%b v1=%h v2=%h want 1 0 5 3",
               d0_busy, d0_rv, d0_v1, d0_v2);
    end
    step();
    n_vec++;
    if (d0_busy !== 1'b0 || d0_rv !== 1'b1 || d0_id !== 1'b0 || d0_rd !== 32'd8) begin
      n_err++;
      $display("FAIL single_rsp: got busy=%b rv=%b id=%b data=%h want 0 1 0 8",
               d0_busy, d0_rv, d0_id, d0_rd);
    end
    step();
    n_vec++;
    if (d0_rv !== 1'b0) begin
      n_err++; $display("FAIL single_rsp_pulse: got rv=%b want 0", d0_rv);
    end
  endtask

  task automatic test_tie();
    do_reset();
    req0_a = 32'd10; req0_b = 32'd3; req0_func = 3'b000; req0_f7 = 1'b1;
    req1_a = 32'hFF; req1_b = 32'h0F; req1_func = 3'b100; req1_f7 = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_vec++;
    if (d0_r0 !== 1'b1 || d0_r1 !== 1'b0 || d1_r0 !== 1'b0 || d1_r1 !== 1'b1) begin
      n_err++;
      $display("FAIL tie_first_grant: got d0=%b%b d1=%b%b want d0=10 d1=01",
               d0_r0, d0_r1, d1_r0, d1_r1);
    end
    step();
    n_vec++;
    if (d0_r0 !== 1'b0 || d0_r1 !== 1'b0 || d0_func !== 3'b000 || d0_f7 !== 1'b1 ||
        d1_func !== 3'b100) begin
      n_err++;
      $display("FAIL tie_exec: got d0 ready=%b%b func=%b f7=%b d1 func=%b want 00 000 1 100",
               d0_r0, d0_r1, d0_func, d0_f7, d1_func);
    end
    step();
    n_vec++;
    if (d0_rv !== 1'b1 || d0_id !== 1'b0 || d0_rd !== 32'd7 || d0_r1 !== 1'b1 ||
        d1_rv !== 1'b1 || d1_id !== 1'b1 || d1_rd !== 32'hF0 || d1_r0 !== 1'b1) begin
      n_err++;
      $display("FAIL tie_rsp1: got d0 id=%b data=%h r1=%b d1 id=%b data=%h r0=%b want 0 7 1 1 f0 1",
               d0_id, d0_rd, d0_r1, d1_id, d1_rd, d1_r0);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_vec++;
    if (d0_busy !== 1'b1 || d0_v1 !== 32'hFF || d1_v1 !== 32'd10) begin
      n_err++;
      $display("FAIL tie_second_accept: got busy=%b d0 v1=%h d1 v1=%h want 1 ff a",
               d0_busy, d0_v1, d1_v1);
    end
    step();
    n_vec++;
    if (d0_rv !== 1'b1 || d0_id !== 1'b1 || d0_rd !== 32'hF0 ||
        d1_rv !== 1'b1 || d1_id !== 1'b0 || d1_rd !== 32'd7) begin
      n_err++;
      $display("FAIL tie_rsp2: got d0 id=%b data=%h d1 id=%b data=%h want 1 f0 0 7",
               d0_id, d0_rd, d1_id, d1_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_id;
    logic [31:0] exp_data;
    do_reset();
    req0_a = 32'd100; req0_b = 32'd1; req0_func = 3'b000; req0_f7 = 1'b0;
    req1_a = 32'h30;  req1_b = 32'h03; req1_func = 3'b110; req1_f7 = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i <= 16; i++) begin
      if (i == 16) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
      end
      if (i % 2 == 0) begin
        if (i < 16) begin
          n_vec++;
          if (d0_busy !== 1'b0 || d0_r0 !== ((i / 2) % 2 == 0) || d0_r1 !== ((i / 2) % 2 == 1)) begin
            n_err++;
            $display("FAIL b2b_grant[%0d]: got busy=%b r0=%b r1=%b", i, d0_busy, d0_r0, d0_r1);
          end
        end
        if (i > 0) begin
          exp_id   = 1'((i / 2 - 1) % 2);
          exp_data = exp_id ? 32'h33 : 32'd101;
          n_vec++;
          if (d0_rv !== 1'b1 || d0_id !== exp_id || d0_rd !== exp_data) begin
            n_err++;
            $display("FAIL b2b_rsp[%0d]: got rv=%b id=%b data=%h want 1 %b %h",
                     i, d0_rv, d0_id, d0_rd, exp_id, exp_data);
          end
        end
      end else begin
        n_vec++;
        if (d0_busy !== 1'b1 || d0_r0 !== 1'b0 || d0_r1 !== 1'b0 || d0_rv !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_exec[%0d]: got busy=%b r0=%b r1=%b rv=%b want 1 0 0 0",
                   i, d0_busy, d0_r0, d0_r1, d0_rv);
        end
      end
      if (i < 16) step();
    end
  endtask

  task automatic test_passthrough();
    logic [2:0]  funcs [3] = '{3'b001, 3'b010, 3'b101};
    logic        f7s   [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] as    [3] = '{32'd1, 32'd1, 32'h8000_0000};
    logic [31:0] bs    [3] = '{32'h3F, 32'd2, 32'd4};
    logic [31:0] exps  [3] = '{32'h8000_0000, 32'h0, 32'h0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req1_a = as[k]; req1_b = bs[k]; req1_func = funcs[k]; req1_f7 = f7s[k];
      req1_valid = 1'b1;
      step();
      req1_valid = 1'b0;
      n_vec++;
      if (d0_func !== funcs[k] || d0_f7 !== f7s[k]) begin
        n_err++;
        $display("FAIL pass_codes[%0d]: got func=%b f7=%b want %b %b",
                 k, d0_func, d0_f7, funcs[k], f7s[k]);
      end
      step();
      n_vec++;
      if (d0_rv !== 1'b1 || d0_id !== 1'b1 || d0_rd !== exps[k]) begin
        n_err++;
        $display("FAIL pass_rsp[%0d]: got rv=%b id=%b data=%h want 1 1 %h",
                 k, d0_rv, d0_id, d0_rd, exps[k]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_a = 32'd9; req0_b = 32'd9; req0_func = 3'b000; req0_f7 = 1'b0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (d0_busy !== 1'b0 || d0_v1 !== 32'h0 || d0_v2 !== 32'h0 || d0_rv !== 1'b0 ||
        d0_rd !== 32'h0 || d0_id !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: got busy=%b v1=%h v2=%h rv=%b data=%h id=%b want all 0",
               d0_busy, d0_v1, d0_v2, d0_rv, d0_rd, d0_id);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (d0_rv !== 1'b0 || d0_busy !== 1'b0) begin
        n_err++; $display("FAIL midreset_norsp[%0d]: got rv=%b busy=%b want 0 0", i, d0_rv, d0_busy);
      end
    end
    req0_a = 32'd2; req0_b = 32'd2;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    n_vec++;
    if (d0_rv !== 1'b1 || d0_rd !== 32'd4 || d0_id !== 1'b0) begin
      n_err++; $display("FAIL midreset_next: got rv=%b data=%h id=%b want 1 4 0", d0_rv, d0_rd, d0_id);
    end
  endtask

  task automatic test_operand_stability();
    do_reset();
    req0_a = 32'h11; req0_b = 32'h22; req0_func = 3'b000; req0_f7 = 1'b0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    req0_a = 32'h1000;
    req0_b = 32'h2000;
    #2;
    n_vec++;
    if (d0_v1 !== 32'h11 || d0_v2 !== 32'h22) begin
      n_err++; $display("FAIL stable_operands: got v1=%h v2=%h want 11 22", d0_v1, d0_v2);
    end
    step();
    n_vec++;
    if (d0_rd !== 32'h33 || d0_v1 !== 32'h11) begin
      n_err++; $display("FAIL stable_result: got data=%h v1=%h want 33 11", d0_rd, d0_v1);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_tie();
    test_back_to_back();
    test_passthrough();
    test_reset_mid_op();
    test_operand_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
